uart_tx: RTL and testbench

Serial transmitter for the board's USB-serial bridge: it accepts one byte per valid/ready handshake and shifts it out on `usb_tx` as an 8N1 frame, LSB first. It is the sending side of the `usb_rx` link. It replaces the echo wire in the top level, so the design can report values such as the counter digit or the selected display position to the host.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_baud_gen.sv | 42 ++++
 rtl/uart_tx.sv | 141 ++++++++++++++
 tb/tb_uart_tx.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, data width and default bit period.
// Used by the transmitter and the future receiver.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS    = 8;
    localparam int unsigned UART_CLKS_PER_BIT = 100;
    localparam int unsigned UART_BIT_IDX_W    = $clog2(UART_DATA_BITS);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running bit-period divider with synchronous clear.
// tick is high for the one cycle in which the counter wraps back to zero.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Next count: held at zero while cleared, otherwise 0..CntMax and wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = ~clr & (cnt_q == CntMax);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a valid/ready byte interface, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit after D7 (8E1 framing).
// tx and ready are registered; busy is simply ready inverted.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [UART_DATA_BITS-1:0] data,
    input  logic                      valid,
    output logic                      ready,
    output logic                      tx,
    output logic                      busy
);

    localparam logic [UART_BIT_IDX_W-1:0] LastBit = UART_BIT_IDX_W'(UART_DATA_BITS - 1);

    uart_state_e                 state_q, state_d;
    logic [UART_DATA_BITS-1:0]   shift_q, shift_d;
    logic [UART_BIT_IDX_W-1:0]   bit_q, bit_d;
    logic                        tx_q, tx_d;
    logic                        ready_q, ready_d;
    logic                        tick;
`ifdef UART_TX_PARITY_EN
    logic                        parity_q, parity_d;
`endif

    // Baud counter is held at zero in IDLE so the start bit gets a full period.
    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (state_q == StIdle),
        .tick (tick)
    );

    // Next state; tx_d is the line level for the state being entered so tx stays registered.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        ready_d = ready_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (valid && ready_q) begin
                    shift_d = data;
                    bit_d   = '0;
                    state_d = StStart;
                    tx_d    = 1'b0;
                    ready_d = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^data;
`endif
                end
            end
            StStart: begin
                if (tick) begin
                    state_d = StData;
                    tx_d    = shift_q[0];
                end
            end
            StData: begin
                if (tick) begin
                    if (bit_q == LastBit) begin
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
                        tx_d    = parity_q;
`else
                        state_d = StStop;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + UART_BIT_IDX_W'(1);
                        tx_d    = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (tick) begin
                    state_d = StStop;
                    tx_d    = 1'b1;
                end
            end
`endif
            StStop: begin
                if (tick) begin
                    state_d = StIdle;
                    tx_d    = 1'b1;
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers; reset drives the line idle-high at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            shift_q <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity of the latched byte, computed once at the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    assign tx    = tx_q;
    assign ready = ready_q;
    assign busy  = ~ready_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a CLKS_PER_BIT=4 instance for frame/handshake
// checks and a CLKS_PER_BIT=100 instance checked by a mid-bit sampling receiver.
// Follows UART_TX_PARITY_EN for the expected frame length.
module tb_uart_tx;

    localparam int C  = 4;
    localparam int CW = 100;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int F = NB * C;

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       tx;
    logic       busy;
    logic [7:0] w_data;
    logic       w_valid;
    logic       w_ready;
    logic       w_tx;
    logic       w_busy;

    int n_tests;
    int n_fail;

    uart_tx #(
        .CLKS_PER_BIT(C)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .data (data),
        .valid(valid),
        .ready(ready),
        .tx   (tx),
        .busy (busy)
    );

    uart_tx #(
        .CLKS_PER_BIT(CW)
    ) u_wide (
        .clk  (clk),
        .rst_n(rst_n),
        .data (w_data),
        .valid(w_valid),
        .ready(w_ready),
        .tx   (w_tx),
        .busy (w_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Line levels in transmit order: start, D0..D7, [parity], stop.
    function automatic logic [10:0] frame_bits(input vec_t v);
        logic [10:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = v.data;
`ifdef UART_TX_PARITY_EN
        f[9]   = v.par;
`endif
        return f;
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("ready wait", ready, 1'b1);
    endtask

    // One handshake, then every cycle of the frame checked; optional valid/data
    // disturbance at cycle index disturb_at (negative disables it).
    task automatic send_frame(input vec_t v, input int disturb_at);
        logic [10:0] exp;
        int          bad;
        int          rdy_bad;
        exp     = frame_bits(v);
        rdy_bad = 0;
        wait_ready();
        data  = v.data;
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        for (int b = 0; b < NB; b++) begin
            bad = 0;
            for (int c = 0; c < C; c++) begin
                @(negedge clk);
                if (tx !== exp[b]) bad++;
                if (ready !== 1'b0 || busy !== 1'b1) rdy_bad++;
                if (b * C + c == disturb_at) begin
                    data  = ~v.data;
                    valid = 1'b1;
                end else begin
                    valid = 1'b0;
                end
            end
            check($sformatf("tx %02h bit%0d bad cycles", v.data, b), bad, 0);
        end
        check($sformatf("busy span %02h", v.data), rdy_bad, 0);
        @(negedge clk);
        check("ready after frame", ready, 1'b1);
        check("busy after frame", busy, 1'b0);
        check("tx after frame", tx, 1'b1);
        @(negedge clk);
        check("no extra start", tx, 1'b1);
        check("still ready", ready, 1'b1);
    endtask

    vec_t vecs[6];
    logic tr_tx[2*F+1];
    logic tr_rdy[2*F+1];
    logic tr_w[NB*CW];

    initial begin
        int   hs_edge;
        int   bad;
        int   rbad;
        int   n;
        logic [10:0] e0;
        logic [10:0] e1;
        logic [7:0]  rx;
        vec_t v0;
        vec_t v1;

        // data, even parity (hand-computed)
        vecs[0] = '{8'hA5, 1'b0};
        vecs[1] = '{8'h00, 1'b0};
        vecs[2] = '{8'hFF, 1'b0};
        vecs[3] = '{8'h3C, 1'b0};
        vecs[4] = '{8'h07, 1'b1};
        vecs[5] = '{8'h03, 1'b0};

        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        data    = 8'h00;
        valid   = 1'b0;
        w_data  = 8'h00;
        w_valid = 1'b0;

        #12;
        check("reset tx", tx, 1'b1);
        check("reset ready", ready, 1'b1);
        check("reset busy", busy, 1'b0);
        check("reset wide tx", w_tx, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven frames.
        for (int i = 0; i < 6; i++) send_frame(vecs[i], -1);

        // valid pulsed with different data mid-frame, twice.
        send_frame(vecs[0], 10);
        send_frame(vecs[3], 25);

        // Back-to-back: valid held high, 0x00 then 0xFF.
        v0      = '{8'h00, 1'b0};
        v1      = '{8'hFF, 1'b0};
        e0      = frame_bits(v0);
        e1      = frame_bits(v1);
        hs_edge = -1;
        wait_ready();
        data  = 8'h00;
        valid = 1'b1;
        @(posedge clk);
        #1;
        data = 8'hFF;
        for (int i = 0; i <= 2 * F; i++) begin
            @(negedge clk);
            tr_tx[i]  = tx;
            tr_rdy[i] = ready;
            if (valid && ready) begin
                hs_edge = i + 1;
                @(posedge clk);
                #1;
                valid = 1'b0;
            end
        end
        valid = 1'b0;
        check("b2b second handshake edge", hs_edge, F + 1);
        bad  = 0;
        rbad = 0;
        for (int i = 0; i < F; i++) begin
            if (tr_tx[i] !== e0[i/C]) bad++;
            if (tr_rdy[i] !== 1'b0) rbad++;
        end
        check("b2b frame0 bits", bad, 0);
        check("gap tx", tr_tx[F], 1'b1);
        check("gap ready", tr_rdy[F], 1'b1);
        bad = 0;
        for (int i = 0; i < F; i++) begin
            if (tr_tx[F+1+i] !== e1[i/C]) bad++;
            if (tr_rdy[F+1+i] !== 1'b0) rbad++;
        end
        check("b2b frame1 bits", bad, 0);
        check("b2b ready low", rbad, 0);
        @(negedge clk);
        check("b2b ready end", ready, 1'b1);

        // Reset mid-frame: line must go high asynchronously, no byte retained.
        wait_ready();
        data  = 8'h00;
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        repeat (7) @(negedge clk);
        check("tx low before reset", tx, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset tx", tx, 1'b1);
        check("async reset ready", ready, 1'b1);
        check("async reset busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad   = 0;
        for (int i = 0; i < 2 * F; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || ready !== 1'b1) bad++;
        end
        check("idle after reset", bad, 0);

        // Wide instance: 0x55, recovered by mid-bit sampling.
        v0 = '{8'h55, 1'b0};
        e0 = frame_bits(v0);
        check("wide ready", w_ready, 1'b1);
        w_data  = 8'h55;
        w_valid = 1'b1;
        @(posedge clk);
        #1;
        w_valid = 1'b0;
        n       = 0;
        @(negedge clk);
        while (w_tx !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("wide start seen", w_tx, 1'b0);
        tr_w[0] = w_tx;
        for (int i = 1; i < NB * CW; i++) begin
            @(negedge clk);
            tr_w[i] = w_tx;
        end
        rx = '0;
        for (int k = 0; k < 8; k++) rx[k] = tr_w[(k + 1) * CW + CW / 2];
        check("wide rx byte", rx, 8'h55);
        check("wide stop mid", tr_w[(NB - 1) * CW + CW / 2], 1'b1);
        bad = 0;
        for (int i = 0; i < NB * CW; i++) begin
            if (tr_w[i] !== e0[i/CW]) bad++;
        end
        check("wide bit widths", bad, 0);
        @(negedge clk);
        check("wide ready after", w_ready, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
